// File: rtl/rca_seq_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract built around one shared 4-bit ripple-carry adder.
// Latency: NIB cycles from operand accept to out_valid; one operation in flight at a time.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, both decoded from state.

module rca (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[4];
endmodule

module rca_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = $clog2(NIB);
    localparam logic [KW-1:0] KLAST = KW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             c_r;
    logic [KW-1:0]    k;

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] nib_s;
    logic       nib_c;

    assign nib_a = a_r[{k, 2'b00} +: 4];
    assign nib_b = b_r[{k, 2'b00} +: 4];

    rca u_rca (
        .a  (nib_a),
        .b  (nib_b),
        .ci (c_r),
        .s  (nib_s),
        .co (nib_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            c_r   <= 1'b0;
            k     <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is folded into the add path as a + ~b + 1.
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        c_r   <= sub ? 1'b1 : cin;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[{k, 2'b00} +: 4] <= nib_s;
                    c_r                  <= nib_c;
                    k                    <= k + 1'b1;
                    if (k == KLAST) begin
                        // Final carry only reaches cout; it never wraps into nibble 0.
                        cout  <= nib_c;
                        ovf   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (nib_s[3] != a_r[WIDTH-1]);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Randomized and directed bench for rca_seq_ctrl against a cycle-count / integer-arithmetic model.
module tb_rca_seq_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    always #5 clk = ~clk;

    rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain integer arithmetic: {ovf, cout, sum}.
    function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                input logic ci, input logic s);
        longint ux, uy, ur, sx, sy, sr, half, cil;
        logic   c, o;
        ux   = longint'(x);
        uy   = longint'(y);
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        cil  = ci ? 64'sd1 : 64'sd0;
        half = 64'sd1 <<< (WIDTH - 1);
        if (s) begin
            ur = ux - uy;
            c  = (ux >= uy);
            sr = sx - sy;
        end else begin
            ur = ux + uy + cil;
            c  = (ur >= 2 * half);
            sr = sx + sy + cil;
        end
        o = (sr >= half) || (sr < -half);
        return {o, c, ur[WIDTH-1:0]};
    endfunction

    // Model: 0 = idle, 1 = computing (m_left cycles to go), 2 = result presented.
    int               m_st = 0;
    int               m_left = 0;
    logic [WIDTH-1:0] m_sum = '0, e_sum = '0;
    logic             m_cout = 1'b0, m_ovf = 1'b0, e_cout = 1'b0, e_ovf = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_st   <= 0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_st == 0) begin
            if (in_valid) begin
                {e_ovf, e_cout, e_sum} <= ref_op(a, b, cin, sub);
                m_left <= NIB;
                m_st   <= 1;
            end
        end else if (m_st == 1) begin
            if (m_left == 1) begin
                m_st   <= 2;
                m_sum  <= e_sum;
                m_cout <= e_cout;
                m_ovf  <= e_ovf;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (out_ready) begin
            m_st <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("in_ready", 32'(in_ready), 32'(m_st == 0));
            chk("out_valid", 32'(out_valid), 32'(m_st == 2));
            chk("busy", 32'(busy), 32'(m_st != 0));
            if (m_st != 1) begin
                chk("sum", 32'(sum), 32'(m_sum));
                chk("cout", 32'(cout), 32'(m_cout));
                chk("ovf", 32'(ovf), 32'(m_ovf));
            end
        end
    end

    task automatic do_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc,
                         input logic xs, input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                         input bit lit, input int hold);
        int t;
        int lat;
        t   = 0;
        lat = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        a         = xa;
        b         = xb;
        cin       = xc;
        sub       = xs;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lit) begin
            chk("latency", 32'(lat), 32'(NIB));
            chk("lit_sum", 32'(sum), 32'(es));
            chk("lit_cout", 32'(cout), 32'(ec));
            chk("lit_ovf", 32'(ovf), 32'(eo));
        end
        if (hold > 0) begin
            in_valid = 1'b1;
            a        = WIDTH'(1);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                if (lit) begin
                    chk("bp_sum", 32'(sum), 32'(es));
                    chk("bp_cout", 32'(cout), 32'(ec));
                    chk("bp_ovf", 32'(ovf), 32'(eo));
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            chk("release_idle", 32'(in_ready), 32'd1);
        end else begin
            @(negedge clk);
            if (lit) chk("done_one_cycle", 32'(in_ready), 32'd1);
        end
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(WIDTH-1){1'b1}}};
            3:       return {1'b1, {(WIDTH-1){1'b0}}};
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
        do_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 0);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1, 0);
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1, 5);

        // Reset two nibbles into an operation; the partial result must never appear.
        while (!in_ready) @(negedge clk);
        a         = 16'h1234;
        b         = 16'h1111;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale_result", 32'(out_valid), 32'd0);
        end
        do_op(16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b1, 0);

        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(pick(), pick(), 1'($urandom), 1'($urandom), '0, 1'b0, 1'b0, 1'b0,
                  int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/rca_seq_ctrl.md
# rca_seq_ctrl

Multi-cycle sequencer that performs WIDTH-bit add/subtract operations using a single 4-bit ripple-carry adder (`rca`) as its only arithmetic resource. It processes one nibble per clock, least-significant first, and keeps the inter-nibble carry in a register. Operands enter through a valid/ready handshake, and results leave through a second valid/ready handshake. The block sits between an operand source, such as a register file or ALU front end, and a result consumer, trading latency for adder area.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4 (derived, not overridable), number of nibble steps per operation.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept; high only in IDLE
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; used for add only
- sub  in  1  1 = compute a - b, 0 = compute a + b + cin
- out_valid  out  1  result available; high only in DONE
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of the MSB; for subtract, 1 = no borrow
- ovf  out  1  two's-complement signed overflow
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready = 1.
  - When in_valid is high at a clk edge, latch a into a_r.
  - Latch b_r = sub ? ~b : b.
  - Load the carry register: c_r = sub ? 1 : cin.
  - Clear nibble index k to 0. Next state is RUN.
  - in_valid is ignored in every other state.
- RUN
  - The `rca` instance inputs are a_r[4k+3:4k], b_r[4k+3:4k] and c_r.
  - Each edge: write the adder sum into sum[4k+3:4k], load c_r with the adder carry, increment k.
  - When k = NIB-1 at the edge, the next state is DONE. At that same edge:
    - cout is loaded with the adder carry.
    - ovf = (a_r[MSB] == b_r[MSB]) && (new sum[MSB] != a_r[MSB]).
- DONE
  - out_valid = 1.
  - sum, cout and ovf are held stable until out_valid && out_ready at an edge; next state is then IDLE.
- Arithmetic is modulo 2^WIDTH.
- Subtract is a + ~b + 1, and cin is ignored.
- sum contents are undefined-but-deterministic during RUN; the consumer must qualify sum with out_valid.
- Only one operation is in flight at a time. There is no pipelining or overlap.

## Timing
- Reset (rst high at an edge) forces:
  - state = IDLE, k = 0, c_r = 0
  - sum = 0, cout = 0, ovf = 0
  - out_valid = 0, busy = 0, in_ready = 1
- Reset wins over every other event in the same cycle, including mid-RUN and in DONE. A mid-operation result is discarded and never presented.
- Accept at edge E0. Nibble i is registered at edge E(i+1). out_valid rises after edge E(NIB), so latency is NIB cycles from accept to out_valid (4 for WIDTH=16).
- The result handshake completes at edge Ed. in_ready is high in the cycle after Ed. Minimum issue interval is NIB+2 cycles.
- in_ready, out_valid and busy are decoded directly from registered state, with no combinational path from in_valid or out_ready.
- If out_ready is already high when out_valid rises, the handshake completes at the first edge in DONE (DONE lasts 1 cycle).
- Carry wrap: the carry out of nibble NIB-1 goes only to cout and never feeds back into nibble 0.

## Test plan
- Add, no carry: a=0x1234, b=0x1111, sub=0, cin=0 -> sum=0x2345, cout=0, ovf=0. out_valid rises exactly 4 cycles after accept.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
- Add with cin: a=0x00FF, b=0x0000, cin=1 -> sum=0x0100, cout=0.
- Signed overflow: a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0. This checks that cin is ignored.
- Subtract with overflow: a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout and ovf stay constant, in_ready=0.
  - A concurrent in_valid with a=0x0001 is not accepted.
  - Release out_ready -> IDLE the next cycle.
- Reset mid-RUN:
  - Assert rst for 1 cycle after 2 nibbles of a=0x1234+0x1111 -> next cycle IDLE, sum=0, out_valid=0, in_ready=1, and no result is ever presented.
  - A following op a=0x0002, b=0x0003 -> sum=0x0005.
